// File: rtl/cache_pkg.sv
// Shared widths, line type, FSM states and address-field helpers for the data cache.
package cache_pkg;
  localparam int NUM_SETS   = 16;
  localparam int LINE_WORDS = 4;
  localparam int WSEL_W     = $clog2(LINE_WORDS);
  localparam int OFF_W      = WSEL_W + 2;
  localparam int IDX_W      = $clog2(NUM_SETS);
  localparam int TAG_W      = 32 - IDX_W - OFF_W;
  localparam int LINE_W     = 32 * LINE_WORDS;

  // Word k of a line sits at bits [32k+31:32k].
  typedef logic [LINE_WORDS-1:0][31:0] line_t;

  typedef enum logic [2:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE, WAIT} state_e;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] a);
    return a[31:32-TAG_W];
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [31:0] a);
    return a[OFF_W+IDX_W-1:OFF_W];
  endfunction

  function automatic logic [WSEL_W-1:0] addr_word(input logic [31:0] a);
    return a[OFF_W-1:2];
  endfunction
endpackage

// File: rtl/cache_array.sv
// Tag/valid/dirty/data storage: combinational read by index, synchronous line or word write.
// Word writes mark the line dirty; line fills mark it valid and clean. Reset clears valid/dirty only.
module cache_array
  import cache_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] idx_i,
  output logic             valid_o,
  output logic             dirty_o,
  output logic [TAG_W-1:0] tag_o,
  output line_t            line_o,
  input  logic             we_i,
  input  logic             line_we_i,
  input  logic [TAG_W-1:0] wtag_i,
  input  logic [WSEL_W-1:0] word_i,
  input  logic [31:0]      wdata_i,
  input  line_t            wline_i
);
  logic [NUM_SETS-1:0] valid_q;
  logic [NUM_SETS-1:0] dirty_q;
  logic [TAG_W-1:0]    tag_q  [NUM_SETS];
  line_t               data_q [NUM_SETS];

  assign valid_o = valid_q[idx_i];
  assign dirty_o = dirty_q[idx_i];
  assign tag_o   = tag_q[idx_i];
  assign line_o  = data_q[idx_i];

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (we_i) begin
      if (line_we_i) begin
        valid_q[idx_i] <= 1'b1;
        dirty_q[idx_i] <= 1'b0;
      end else begin
        dirty_q[idx_i] <= 1'b1;
      end
    end
  end

  // Tag and data storage carry no reset so they can map onto RAM.
  always_ff @(posedge clk) begin
    if (we_i) begin
      if (line_we_i) begin
        tag_q[idx_i]  <= wtag_i;
        data_q[idx_i] <= wline_i;
      end else begin
        data_q[idx_i][word_i] <= wdata_i;
      end
    end
  end
endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-back/write-allocate cache; hit responds 2 cycles after the handshake.
// CPU stalls while cpu_ready=0; memory side holds requests until mem_req_ready and waits for mem_resp_valid.
module data_cache
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req_valid,
  input  logic              cpu_req_write,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_ready,
  output logic              cpu_resp_valid,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_hit,
  output logic              mem_req_valid,
  output logic              mem_req_write,
  output logic [31:0]       mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic              mem_req_ready,
  input  logic              mem_resp_valid,
  input  logic [LINE_W-1:0] mem_rdata,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
);
  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        write_q, write_d;
  logic        missed_q, missed_d;
  logic        resp_q, resp_d;
  logic [31:0] rdata_q, rdata_d;
  logic        hit_q, hit_d;
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  logic             rd_valid, rd_dirty, arr_we, arr_line_we, tag_hit;
  logic [TAG_W-1:0] rd_tag;
  line_t            rd_line;
  logic             unused_addr_bits;

  assign unused_addr_bits = ^addr_q[1:0];

  cache_array u_array (
    .clk       (clk),
    .reset     (reset),
    .idx_i     (addr_idx(addr_q)),
    .valid_o   (rd_valid),
    .dirty_o   (rd_dirty),
    .tag_o     (rd_tag),
    .line_o    (rd_line),
    .we_i      (arr_we && !reset),
    .line_we_i (arr_line_we),
    .wtag_i    (addr_tag(addr_q)),
    .word_i    (addr_word(addr_q)),
    .wdata_i   (wdata_q),
    .wline_i   (mem_rdata)
  );

  assign tag_hit = rd_valid && (rd_tag == addr_tag(addr_q));

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    write_d     = write_q;
    missed_d    = missed_q;
    resp_d      = 1'b0;
    rdata_d     = rdata_q;
    hit_d       = hit_q;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    arr_we      = 1'b0;
    arr_line_we = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_req_valid) begin
          addr_d   = cpu_addr;
          wdata_d  = cpu_wdata;
          write_d  = cpu_req_write;
          missed_d = 1'b0;
          state_d  = COMPARE;
        end
      end
      COMPARE: begin
        if (tag_hit) begin
          resp_d  = 1'b1;
          rdata_d = write_q ? wdata_q : rd_line[addr_word(addr_q)];
          hit_d   = !missed_q;
          arr_we  = write_q;
          if (missed_q) miss_cnt_d = miss_cnt_q + 32'd1;
          else          hit_cnt_d  = hit_cnt_q + 32'd1;
          state_d = IDLE;
        end else begin
          missed_d = 1'b1;
          state_d  = (rd_valid && rd_dirty) ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: if (mem_req_ready) state_d = ALLOCATE;
      ALLOCATE:  if (mem_req_ready) state_d = WAIT;
      WAIT: begin
        // The refilled line is retried in COMPARE, which also merges a pending store.
        if (mem_resp_valid) begin
          arr_we      = 1'b1;
          arr_line_we = 1'b1;
          state_d     = COMPARE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      write_q    <= 1'b0;
      missed_q   <= 1'b0;
      resp_q     <= 1'b0;
      rdata_q    <= '0;
      hit_q      <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      write_q    <= write_d;
      missed_q   <= missed_d;
      resp_q     <= resp_d;
      rdata_q    <= rdata_d;
      hit_q      <= hit_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign cpu_ready      = (state_q == IDLE);
  assign cpu_resp_valid = resp_q;
  assign cpu_rdata      = rdata_q;
  assign cpu_hit        = hit_q;
  assign mem_req_valid  = (state_q == WRITEBACK) || (state_q == ALLOCATE);
  assign mem_req_write  = (state_q == WRITEBACK);
  assign mem_addr       = (state_q == WRITEBACK) ? {rd_tag, addr_idx(addr_q), {OFF_W{1'b0}}}
                                                 : {addr_tag(addr_q), addr_idx(addr_q), {OFF_W{1'b0}}};
  assign mem_wdata      = rd_line;
  assign hit_count      = hit_cnt_q;
  assign miss_count     = miss_cnt_q;
endmodule
